// File: rtl/matrix_cps_pkg.sv
// Shared types for the matrix dispatcher: FSM states, execution-unit ids,
// rw-queue entries and operand slots.
package matrix_cps_pkg;

  localparam int CPS_ID_WIDTH = 4;
  localparam int CPS_REG_W    = 8;

  typedef enum logic {
    ST_IDLE,
    ST_PUSH
  } disp_state_t;

  typedef enum logic [1:0] {
    EU_MATMUL    = 2'd0,
    EU_LOADSTORE = 2'd1,
    EU_ELEMWISE  = 2'd2
  } execution_units_t;

  typedef struct packed {
    logic                    rvalid;
    logic                    wready;
    logic [CPS_ID_WIDTH-1:0] id;
  } rw_entry_t;

  typedef struct packed {
    logic [CPS_REG_W-1:0] reg_idx;
    logic                 is_write;
  } operand_slot_t;

endpackage

// File: rtl/matrix_dispatcher_nport_if.sv
// Decoder-to-dispatcher instruction handshake bundle.
interface matrix_dispatcher_nport_if #(
  parameter int N_REGS         = 8,
  parameter int N_READ_OPS     = 3,
  parameter int NUM_EXEC_UNITS = 3,
  parameter int ID_WIDTH       = 4,
  parameter int PAYLOAD_W      = 72
);
  logic                                  instr_valid_i;
  logic                                  instr_ready_o;
  logic [ID_WIDTH-1:0]                   instr_id_i;
  logic [PAYLOAD_W-1:0]                  payload_i;
  logic [$clog2(NUM_EXEC_UNITS)-1:0]     exec_unit_i;
  logic [$clog2(N_READ_OPS+1)-1:0]       n_read_i;
  logic [N_READ_OPS*$clog2(N_REGS)-1:0]  read_regs_i;
  logic                                  wb_i;
  logic [$clog2(N_REGS)-1:0]             wb_reg_i;

  modport master (
    output instr_valid_i, instr_id_i, payload_i, exec_unit_i,
           n_read_i, read_regs_i, wb_i, wb_reg_i,
    input  instr_ready_o
  );

  modport slave (
    input  instr_valid_i, instr_id_i, payload_i, exec_unit_i,
           n_read_i, read_regs_i, wb_i, wb_reg_i,
    output instr_ready_o
  );
endinterface

// File: rtl/matrix_dispatch_arbiter.sv
// Per-cycle push selector: picks which pending operands enter their rw queue.
// Optional full-stall flag exists only with MATRIX_DISPATCHER_PERF_CNT_EN.
module matrix_dispatch_arbiter
  import matrix_cps_pkg::*;
#(
  parameter int N_REGS     = 8,
  parameter int N_READ_OPS = 3,
  localparam int REG_W     = $clog2(N_REGS),
  localparam int N_OPS     = N_READ_OPS + 1
) (
  input  logic [N_OPS-1:0]       pending_i,
  input  logic [N_OPS*REG_W-1:0] op_regs_i,
  input  logic [N_REGS-1:0]      rw_full_i,
  output logic [N_REGS-1:0]      push_o,
  output logic [N_REGS-1:0]      rvalid_o,
  output logic [N_REGS-1:0]      wready_o,
`ifdef MATRIX_DISPATCHER_PERF_CNT_EN
  output logic                   full_block_o,
`endif
  output logic [N_OPS-1:0]       clear_o
);

  operand_slot_t slots [N_OPS];

  // Lower operand index wins a shared register, so each queue sees at most one entry per cycle.
  always_comb begin
    logic [N_REGS-1:0] hit;
    logic              full;
    logic              conflict;
    push_o   = '0;
    rvalid_o = '0;
    wready_o = '0;
    clear_o  = '0;
`ifdef MATRIX_DISPATCHER_PERF_CNT_EN
    full_block_o = 1'b0;
`endif
    for (int k = 0; k < N_OPS; k++) begin
      slots[k].reg_idx  = CPS_REG_W'(op_regs_i[k*REG_W +: REG_W]);
      slots[k].is_write = (k == N_OPS - 1);
    end
    for (int k = 0; k < N_OPS; k++) begin
      hit = '0;
      for (int r = 0; r < N_REGS; r++) begin
        hit[r] = (slots[k].reg_idx == CPS_REG_W'(r));
      end
      full     = |(hit & rw_full_i);
      conflict = 1'b0;
      for (int j = 0; j < N_OPS; j++) begin
        if (j < k && pending_i[j] && (slots[j].reg_idx == slots[k].reg_idx)) begin
          conflict = 1'b1;
        end
      end
`ifdef MATRIX_DISPATCHER_PERF_CNT_EN
      if (pending_i[k] && full) begin
        full_block_o = 1'b1;
      end
`endif
      if (pending_i[k] && !full && !conflict) begin
        clear_o[k] = 1'b1;
        push_o     = push_o | hit;
        if (slots[k].is_write) begin
          wready_o = wready_o | hit;
        end else begin
          rvalid_o = rvalid_o | hit;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_dispatcher_nport.sv
// Matrix instruction dispatcher: accepts decoded instructions, reserves rw-queue
// slots per operand and pulses dispatch. MATRIX_DISPATCHER_PERF_CNT_EN adds perf counters.
module matrix_dispatcher_nport
  import matrix_cps_pkg::*;
#(
  parameter int N_REGS         = 8,
  parameter int N_READ_OPS     = 3,
  parameter int NUM_EXEC_UNITS = 3,
  parameter int ID_WIDTH       = 4,
  parameter int PAYLOAD_W      = 72,
  localparam int REG_W         = $clog2(N_REGS),
  localparam int EU_W          = $clog2(NUM_EXEC_UNITS),
  localparam int N_OPS         = N_READ_OPS + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  matrix_dispatcher_nport_if.slave    instr_if,
  input  logic [N_REGS-1:0]           waw_busy_i,
  input  logic [N_REGS-1:0]           rw_full_i,
  output logic [N_REGS-1:0]           rw_push_o,
  output logic [N_REGS-1:0]           rw_rvalid_o,
  output logic [N_REGS-1:0]           rw_wready_o,
  output logic [ID_WIDTH-1:0]         rw_id_o,
  input  logic [NUM_EXEC_UNITS-1:0]   issue_full_i,
  output logic [NUM_EXEC_UNITS-1:0]   dispatch_o,
  output logic [ID_WIDTH-1:0]         disp_id_o,
  output logic [PAYLOAD_W-1:0]        payload_o,
  output logic [N_READ_OPS*REG_W-1:0] reg_rd_o,
  output logic [REG_W-1:0]            reg_wd_o,
`ifdef MATRIX_DISPATCHER_PERF_CNT_EN
  output logic [31:0]                 perf_dispatch_o,
  output logic [31:0]                 perf_waw_stall_o,
  output logic [31:0]                 perf_full_stall_o,
`endif
  output logic                        busy_o
);

  disp_state_t               state_q, state_d;
  logic [N_OPS-1:0]          pending_q, pending_d, new_pend, clear;
  logic                      disp_pulse_q;
  logic [EU_W-1:0]           unit_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [PAYLOAD_W-1:0]      payload_q;
  logic [N_READ_OPS*REG_W-1:0] rd_q;
  logic [REG_W-1:0]          wd_q;
  logic                      waw_block, can_accept, done, accept;
`ifdef MATRIX_DISPATCHER_PERF_CNT_EN
  logic                      full_block;
  logic [31:0]               perf_disp_q, perf_waw_q, perf_full_q;
`endif

  matrix_dispatch_arbiter #(
    .N_REGS     (N_REGS),
    .N_READ_OPS (N_READ_OPS)
  ) u_arbiter (
    .pending_i    (pending_q),
    .op_regs_i    ({wd_q, rd_q}),
    .rw_full_i    (rw_full_i),
    .push_o       (rw_push_o),
    .rvalid_o     (rw_rvalid_o),
    .wready_o     (rw_wready_o),
`ifdef MATRIX_DISPATCHER_PERF_CNT_EN
    .full_block_o (full_block),
`endif
    .clear_o      (clear)
  );

  // A write to a register still waiting for its own reservation counts as a WAW hazard too.
  always_comb begin
    waw_block  = instr_if.wb_i & (waw_busy_i[instr_if.wb_reg_i] |
                 (pending_q[N_OPS-1] & (wd_q == instr_if.wb_reg_i)));
    can_accept = instr_if.instr_valid_i & ~issue_full_i[instr_if.exec_unit_i] & ~waw_block;
    done       = ((pending_q & ~clear) == '0);
    accept     = rst_ni & can_accept & ((state_q == ST_IDLE) | done);
    instr_if.instr_ready_o = accept;
    for (int k = 0; k < N_READ_OPS; k++) begin
      new_pend[k] = (int'(instr_if.n_read_i) > k);
    end
    new_pend[N_OPS-1] = instr_if.wb_i;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q & ~clear;
    if (accept) begin
      pending_d = new_pend;
      state_d   = (|new_pend) ? ST_PUSH : ST_IDLE;
    end else if (done) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      disp_pulse_q <= 1'b0;
      unit_q       <= '0;
      id_q         <= '0;
      payload_q    <= '0;
      rd_q         <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      disp_pulse_q <= accept;
      if (accept) begin
        unit_q    <= instr_if.exec_unit_i;
        id_q      <= instr_if.instr_id_i;
        payload_q <= instr_if.payload_i;
        rd_q      <= instr_if.read_regs_i;
        wd_q      <= instr_if.wb_reg_i;
      end
    end
  end

  always_comb begin
    dispatch_o = '0;
    for (int u = 0; u < NUM_EXEC_UNITS; u++) begin
      dispatch_o[u] = disp_pulse_q & (unit_q == EU_W'(u));
    end
  end

  assign rw_id_o   = id_q;
  assign disp_id_o = id_q;
  assign payload_o = payload_q;
  assign reg_rd_o  = rd_q;
  assign reg_wd_o  = wd_q;
  assign busy_o    = (state_q == ST_PUSH);

`ifdef MATRIX_DISPATCHER_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_disp_q <= '0;
      perf_waw_q  <= '0;
      perf_full_q <= '0;
    end else begin
      if (accept && perf_disp_q != '1) begin
        perf_disp_q <= perf_disp_q + 32'd1;
      end
      if (instr_if.instr_valid_i && waw_block && perf_waw_q != '1) begin
        perf_waw_q <= perf_waw_q + 32'd1;
      end
      if (state_q == ST_PUSH && full_block && perf_full_q != '1) begin
        perf_full_q <= perf_full_q + 32'd1;
      end
    end
  end

  assign perf_dispatch_o   = perf_disp_q;
  assign perf_waw_stall_o  = perf_waw_q;
  assign perf_full_stall_o = perf_full_q;
`endif

endmodule

// File: tb/tb_matrix_dispatcher_nport.sv
// Directed self-checking bench for matrix_dispatcher_nport.
module tb_matrix_dispatcher_nport;
  import matrix_cps_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [7:0] waw_busy, rw_full, rw_push, rw_rvalid, rw_wready;
  logic [3:0] rw_id, disp_id;
  logic [2:0] issue_full, dispatch;
  logic [71:0] payload_o;
  logic [8:0] reg_rd;
  logic [2:0] reg_wd;
  logic       busy;
  int         checks = 0;
  int         errors = 0;
`ifdef MATRIX_DISPATCHER_PERF_CNT_EN
  logic [31:0] perf_disp, perf_waw, perf_full;
`endif

  always #5 clk = ~clk;

  matrix_dispatcher_nport_if #(
    .N_REGS(8), .N_READ_OPS(3), .NUM_EXEC_UNITS(3), .ID_WIDTH(4), .PAYLOAD_W(72)
  ) dif ();

  matrix_dispatcher_nport #(
    .N_REGS(8), .N_READ_OPS(3), .NUM_EXEC_UNITS(3), .ID_WIDTH(4), .PAYLOAD_W(72)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .instr_if          (dif),
    .waw_busy_i        (waw_busy),
    .rw_full_i         (rw_full),
    .rw_push_o         (rw_push),
    .rw_rvalid_o       (rw_rvalid),
    .rw_wready_o       (rw_wready),
    .rw_id_o           (rw_id),
    .issue_full_i      (issue_full),
    .dispatch_o        (dispatch),
    .disp_id_o         (disp_id),
    .payload_o         (payload_o),
    .reg_rd_o          (reg_rd),
    .reg_wd_o          (reg_wd),
`ifdef MATRIX_DISPATCHER_PERF_CNT_EN
    .perf_dispatch_o   (perf_disp),
    .perf_waw_stall_o  (perf_waw),
    .perf_full_stall_o (perf_full),
`endif
    .busy_o            (busy)
  );

  task automatic idle_inputs();
    dif.instr_valid_i = 1'b0;
    dif.instr_id_i    = '0;
    dif.payload_i     = '0;
    dif.exec_unit_i   = '0;
    dif.n_read_i      = '0;
    dif.read_regs_i   = '0;
    dif.wb_i          = 1'b0;
    dif.wb_reg_i      = '0;
    waw_busy          = '0;
    rw_full           = '0;
    issue_full        = '0;
  endtask

  task automatic drive_instr(input logic [3:0] id, input logic [1:0] unit, input logic [1:0] n,
                             input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2,
                             input logic wb, input logic [2:0] wreg);
    dif.instr_valid_i = 1'b1;
    dif.instr_id_i    = id;
    dif.payload_i     = {9{4'hA, id}};
    dif.exec_unit_i   = unit;
    dif.n_read_i      = n;
    dif.read_regs_i   = {r2, r1, r0};
    dif.wb_i          = wb;
    dif.wb_reg_i      = wreg;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    dif.instr_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", dif.instr_ready_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dispatch !== 3'b000) begin errors++; $display("[TB] FAIL reset_dispatch: got %b want 000", dispatch); end
    checks++; if (rw_push !== 8'h00 || rw_rvalid !== 8'h00 || rw_wready !== 8'h00) begin errors++; $display("[TB] FAIL reset_push: push %h rvalid %h wready %h want 00", rw_push, rw_rvalid, rw_wready); end
    checks++; if (disp_id !== 4'h0 || payload_o !== 72'h0 || reg_rd !== 9'h0 || reg_wd !== 3'h0) begin errors++; $display("[TB] FAIL reset_latched: id %h payload %h rd %h wd %h want 0", disp_id, payload_o, reg_rd, reg_wd); end
    dif.instr_valid_i = 1'b0;
    rst_ni = 1'b1;
  endtask

  task automatic test_single_push();
    @(negedge clk);
    drive_instr(4'h5, EU_LOADSTORE, 2'd3, 3'd2, 3'd5, 3'd7, 1'b1, 3'd3);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b want 1", dif.instr_ready_o); end
    @(negedge clk);
    dif.instr_valid_i = 1'b0;
    #1;
    checks++; if (rw_push !== 8'hAC || rw_rvalid !== 8'hA4 || rw_wready !== 8'h08) begin errors++; $display("[TB] FAIL single_push: push %h rvalid %h wready %h want AC A4 08", rw_push, rw_rvalid, rw_wready); end
    checks++; if (dispatch !== 3'b010) begin errors++; $display("[TB] FAIL single_dispatch: got %b want 010", dispatch); end
    checks++; if (rw_id !== 4'h5 || disp_id !== 4'h5) begin errors++; $display("[TB] FAIL single_id: rw_id %h disp_id %h want 5", rw_id, disp_id); end
    checks++; if (reg_rd !== 9'h1EA || reg_wd !== 3'd3 || payload_o !== {9{8'hA5}}) begin errors++; $display("[TB] FAIL single_latched: rd %h wd %h payload %h want 1ea 3 a5..", reg_rd, reg_wd, payload_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || dispatch !== 3'b000 || rw_push !== 8'h00) begin errors++; $display("[TB] FAIL single_after: busy %b dispatch %b push %h want 0", busy, dispatch, rw_push); end
  endtask

  task automatic test_duplicate_regs();
    logic [7:0] exp_rv, exp_wr;
    logic       exp_rdy;
    @(negedge clk);
    drive_instr(4'h3, EU_MATMUL, 2'd3, 3'd4, 3'd4, 3'd4, 1'b1, 3'd4);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL dup_accept: got %b want 1", dif.instr_ready_o); end
    @(negedge clk);
    drive_instr(4'h9, EU_ELEMWISE, 2'd1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      exp_rv  = (c < 4) ? 8'h10 : 8'h00;
      exp_wr  = (c == 4) ? 8'h10 : 8'h00;
      exp_rdy = (c == 4);
      checks++; if (rw_push !== 8'h10 || rw_rvalid !== exp_rv || rw_wready !== exp_wr) begin errors++; $display("[TB] FAIL dup_push c%0d: push %h rvalid %h wready %h want 10 %h %h", c, rw_push, rw_rvalid, rw_wready, exp_rv, exp_wr); end
      checks++; if (dif.instr_ready_o !== exp_rdy) begin errors++; $display("[TB] FAIL dup_ready c%0d: got %b want %b", c, dif.instr_ready_o, exp_rdy); end
      if (c == 1) begin
        checks++; if (dispatch !== 3'b001) begin errors++; $display("[TB] FAIL dup_dispatch: got %b want 001", dispatch); end
      end
    end
    @(negedge clk);
    dif.instr_valid_i = 1'b0;
    #1;
    checks++; if (rw_push !== 8'h01 || rw_rvalid !== 8'h01 || dispatch !== 3'b100 || disp_id !== 4'h9 || busy !== 1'b1) begin errors++; $display("[TB] FAIL dup_next: push %h rvalid %h dispatch %b id %h busy %b want 01 01 100 9 1", rw_push, rw_rvalid, dispatch, disp_id, busy); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL dup_idle: busy %b want 0", busy); end
  endtask

  task automatic test_full_stall();
    logic [7:0] exp_push;
    @(negedge clk);
    rw_full = 8'h20;
    drive_instr(4'h6, EU_LOADSTORE, 2'd2, 3'd1, 3'd5, 3'd7, 1'b0, 3'd0);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL full_accept: got %b want 1", dif.instr_ready_o); end
    @(negedge clk);
    dif.instr_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 4) rw_full = 8'h00;
      #1;
      exp_push = (c == 1) ? 8'h02 : ((c == 4) ? 8'h20 : 8'h00);
      checks++; if (rw_push !== exp_push || rw_rvalid !== exp_push || rw_wready !== 8'h00) begin errors++; $display("[TB] FAIL full_push c%0d: push %h rvalid %h wready %h want %h %h 00", c, rw_push, rw_rvalid, rw_wready, exp_push, exp_push); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL full_busy c%0d: got %b want 1", c, busy); end
    end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || rw_push !== 8'h00) begin errors++; $display("[TB] FAIL full_idle: busy %b push %h want 0", busy, rw_push); end
  endtask

  task automatic test_hazards();
    @(negedge clk);
    waw_busy = 8'h08;
    drive_instr(4'h7, EU_ELEMWISE, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd3);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL waw_block0: got %b want 0", dif.instr_ready_o); end
    @(negedge clk);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b0 || busy !== 1'b0 || dispatch !== 3'b000) begin errors++; $display("[TB] FAIL waw_block1: ready %b busy %b dispatch %b want 0", dif.instr_ready_o, busy, dispatch); end
    @(negedge clk);
    waw_busy = 8'h00;
    #1;
    checks++; if (dif.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL waw_release: got %b want 1", dif.instr_ready_o); end
    @(negedge clk);
    dif.instr_valid_i = 1'b0;
    #1;
    checks++; if (dispatch !== 3'b100 || rw_push !== 8'h08 || rw_wready !== 8'h08 || rw_rvalid !== 8'h00) begin errors++; $display("[TB] FAIL waw_dispatch: dispatch %b push %h wready %h rvalid %h want 100 08 08 00", dispatch, rw_push, rw_wready, rw_rvalid); end
    @(negedge clk);
    issue_full = 3'b100;
    drive_instr(4'h8, EU_ELEMWISE, 2'd1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL issue_full0: got %b want 0", dif.instr_ready_o); end
    @(negedge clk);
    issue_full = 3'b011;
    #1;
    checks++; if (dispatch !== 3'b000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL issue_full1: dispatch %b busy %b want 0", dispatch, busy); end
    checks++; if (dif.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL issue_other: got %b want 1", dif.instr_ready_o); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (dispatch !== 3'b100 || disp_id !== 4'h8 || rw_push !== 8'h01) begin errors++; $display("[TB] FAIL issue_dispatch: dispatch %b id %h push %h want 100 8 01", dispatch, disp_id, rw_push); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_instr(4'h1, EU_MATMUL, 2'd1, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_a: got %b want 1", dif.instr_ready_o); end
    @(negedge clk);
    drive_instr(4'h2, EU_LOADSTORE, 2'd1, 3'd6, 3'd0, 3'd0, 1'b1, 3'd1);
    #1;
    checks++; if (rw_push !== 8'h04 || dispatch !== 3'b001 || disp_id !== 4'h1) begin errors++; $display("[TB] FAIL b2b_first: push %h dispatch %b id %h want 04 001 1", rw_push, dispatch, disp_id); end
    checks++; if (dif.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_b: got %b want 1", dif.instr_ready_o); end
    @(negedge clk);
    dif.instr_valid_i = 1'b0;
    #1;
    checks++; if (rw_push !== 8'h42 || rw_rvalid !== 8'h40 || rw_wready !== 8'h02 || dispatch !== 3'b010 || rw_id !== 4'h2 || busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second: push %h rvalid %h wready %h dispatch %b id %h busy %b want 42 40 02 010 2 1", rw_push, rw_rvalid, rw_wready, dispatch, rw_id, busy); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || dispatch !== 3'b000) begin errors++; $display("[TB] FAIL b2b_idle: busy %b dispatch %b want 0", busy, dispatch); end
  endtask

  task automatic test_zero_operand();
    @(negedge clk);
    drive_instr(4'hE, EU_LOADSTORE, 2'd0, 3'd1, 3'd2, 3'd3, 1'b0, 3'd5);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL zero_accept: got %b want 1", dif.instr_ready_o); end
    @(negedge clk);
    dif.instr_valid_i = 1'b0;
    #1;
    checks++; if (dispatch !== 3'b010 || busy !== 1'b0 || rw_push !== 8'h00 || disp_id !== 4'hE) begin errors++; $display("[TB] FAIL zero_dispatch: dispatch %b busy %b push %h id %h want 010 0 00 e", dispatch, busy, rw_push, disp_id); end
  endtask

  task automatic test_reset_mid_push();
    @(negedge clk);
    rw_full = 8'h40;
    drive_instr(4'hC, EU_MATMUL, 2'd1, 3'd6, 3'd0, 3'd0, 1'b0, 3'd0);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_accept: got %b want 1", dif.instr_ready_o); end
    @(negedge clk);
    dif.instr_valid_i = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || rw_push !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_stalled: busy %b push %h want 1 00", busy, rw_push); end
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rw_push !== 8'h00 || dispatch !== 3'b000 || disp_id !== 4'h0) begin errors++; $display("[TB] FAIL rst_mid_cleared: busy %b push %h dispatch %b id %h want 0", busy, rw_push, dispatch, disp_id); end
    rw_full = 8'h00;
    drive_instr(4'hD, EU_ELEMWISE, 2'd1, 3'd3, 3'd0, 3'd0, 1'b0, 3'd0);
    #1;
    checks++; if (dif.instr_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_reaccept: got %b want 1", dif.instr_ready_o); end
    @(negedge clk);
    dif.instr_valid_i = 1'b0;
    #1;
    checks++; if (rw_push !== 8'h08 || dispatch !== 3'b100 || disp_id !== 4'hD) begin errors++; $display("[TB] FAIL rst_mid_new: push %h dispatch %b id %h want 08 100 d", rw_push, dispatch, disp_id); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_idle: busy %b want 0", busy); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting matrix_dispatcher_nport bench");
    test_reset();
    test_single_push();
    test_duplicate_regs();
    test_full_stall();
    test_hazards();
    test_back_to_back();
    test_zero_operand();
    test_reset_mid_push();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_dispatcher_nport.md
Name: matrix_dispatcher_nport

Overview:
Parametrised next-generation matrix instruction dispatcher between decoder and RF sequencer/execution units. Accepts one decoded matrix instruction per handshake and checks issue-queue space and WAW hazards. It then pushes one read/write reservation per matrix operand into the per-register rw queues and pulses dispatch to the selected execution unit. Generalised to N_READ_OPS read operands, with same-cycle multi-register pushes, per-operand stall tracking and back-to-back acceptance.

Parameters:
N_REGS, 8, number of matrix registers / rw queues
N_READ_OPS, 3, max matrix read operands per instruction (>=1)
NUM_EXEC_UNITS, 3, number of execution units
ID_WIDTH, 4, instruction id width
PAYLOAD_W, 72, opaque payload width (rs, rs_valid, datatype, is_store, is_float) carried to the exec units

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
instr_valid_i  in  1  decoder instruction valid
instr_ready_o  out  1  instruction accepted this cycle
instr_id_i  in  ID_WIDTH  instruction id
payload_i  in  PAYLOAD_W  opaque payload
exec_unit_i  in  $clog2(NUM_EXEC_UNITS)  target execution unit
n_read_i  in  $clog2(N_READ_OPS+1)  number of valid read operands
read_regs_i  in  N_READ_OPS*$clog2(N_REGS)  read register indices, operand 0 in LSBs
wb_i  in  1  instruction writes a matrix register
wb_reg_i  in  $clog2(N_REGS)  destination register
waw_busy_i  in  N_REGS  register has an in-flight write (from RF sequencer scoreboard)
rw_full_i  in  N_REGS  rw queue full
rw_push_o  out  N_REGS  push into rw queue r
rw_rvalid_o  out  N_REGS  pushed entry is a read reservation
rw_wready_o  out  N_REGS  pushed entry is a write reservation
rw_id_o  out  ID_WIDTH  id for all pushed entries
issue_full_i  in  NUM_EXEC_UNITS  exec-unit issue queue full
dispatch_o  out  NUM_EXEC_UNITS  one-cycle dispatch pulse
disp_id_o  out  ID_WIDTH  id of latched instruction
payload_o  out  PAYLOAD_W  latched payload
reg_rd_o  out  N_READ_OPS*$clog2(N_REGS)  latched read registers
reg_wd_o  out  $clog2(N_REGS)  latched destination
busy_o  out  1  operand pushes outstanding

Behaviour:
- FSM: IDLE, PUSH. can_accept = instr_valid_i & ~issue_full_i[exec_unit_i] & ~(wb_i & (waw_busy_i[wb_reg_i] | latched pending write to wb_reg_i)).
- instr_ready_o = rst_ni & can_accept & (state==IDLE | done). Combinational.
- On accept: latch id, payload, registers, exec unit. pending[k] = (k < min(n_read_i, N_READ_OPS)) for reads; pending_w = wb_i. dispatch_o[exec_unit_i] = 1 in the next cycle, for exactly one cycle. Next state is PUSH if any bit is pending, else IDLE. Zero-operand instructions dispatch with no pushes.
- PUSH, each cycle: operand k (reads ascending, write last) is pushed iff pending, rw_full_i[its reg]==0, and no lower-priority-index pending operand targets the same register.
  - At most one entry per queue per cycle; rvalid and wready are never both set on one queue.
  - Duplicate registers serialize, one operand per cycle.
  - Pushed bits clear at the clock edge.
- Push outputs are combinational from registered pending bits and rw_full_i. rw_id_o = latched id.
- done = every still-pending operand is pushed this cycle. If done and a new instruction is accepted, stay in PUSH with the new pending set (back-to-back, no bubble). If done with no accept, go to IDLE.
- busy_o = state==PUSH.
- A full queue stalls only operands targeting it. Other operands proceed.
- Reset (synchronous, rst_ni low at an edge): state IDLE, pending cleared, dispatch_o, rw_push_o, rw_rvalid_o, rw_wready_o, busy_o = 0. Latched id, payload and registers = 0. Aborts any in-flight pushes; already-pushed entries are not recalled.
- n_read_i > N_READ_OPS is clamped.
- Register indices are not range-checked beyond their width.

Optional Feature:
Macro MATRIX_DISPATCHER_PERF_CNT_EN. When defined, adds 32-bit saturating output counters, cleared on reset:
- perf_dispatch_o: accepted instructions.
- perf_waw_stall_o: cycles with instr_valid_i high and the WAW term blocking.
- perf_full_stall_o: PUSH cycles where at least one pending operand is blocked by rw_full_i.

When undefined, these ports and counters do not exist. Core behaviour is identical either way.

Decomposition:
Shared package matrix_cps_pkg holds:
- the rw-entry typedef (rvalid, wready, id);
- the execution_units_t enum;
- the operand-slot struct (reg, is_write).

Sub-module matrix_dispatch_arbiter: combinational per-cycle push selector. It takes pending bits, operand registers and rw_full_i, and returns the push vectors and the cleared-bit mask.

Test Plan:
- Operands reads {2,5,7}, wb=1 reg 3, all queues empty → single PUSH cycle: push on regs 2,5,7 (rvalid) and 3 (wready); dispatch pulse on exec_unit the cycle after accept.
- Reads {4,4,4}, wb reg 4 → four consecutive push cycles on queue 4: three rvalid, then wready. instr_ready_o high again only in the fourth PUSH cycle.
- rw_full_i[5] held 3 cycles with reads {1,5} → reg 1 pushed immediately, reg 5 pushed the cycle full drops, busy_o high throughout.
- waw_busy_i[3]=1 with wb_reg 3 → instr_ready_o=0 until it drops. issue_full_i[exec_unit]=1 → no accept.
- Back-to-back: two no-conflict instructions → second accepted in the done cycle of the first, dispatch_o pulses on consecutive cycles.
- Reset asserted mid-PUSH with pending reg 6 blocked → next cycle all pushes/dispatch 0, state IDLE, new instruction accepted normally.
